// File: rtl/csr_ctrl.sv
// Zicsr control stage: decodes CSR ops, maps CSR numbers onto a 5-entry file,
// sequences trap entry / mret and initialises the (reset-less) CSR file.
module csr_ctrl #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_csr,
    input  logic [31:0] req_rs1_val,
    input  logic [4:0]  req_zimm,
    input  logic        req_src_zero,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    output logic        trap_ack,
    input  logic        mret_valid,
    output logic        mret_ack,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [11:0] csr_addr1,
    output logic [11:0] csr_addr2,
    output logic [11:0] csr_addr3,
    output logic        csr_we1,
    output logic        csr_we2,
    output logic        csr_we3,
    output logic [31:0] csr_wd1,
    output logic [31:0] csr_wd2,
    output logic [31:0] csr_wd3,
    input  logic [31:0] csr_rd1,
    input  logic [31:0] csr_rd2,
    input  logic [31:0] csr_rd3
);
    typedef enum logic [2:0] {INIT0, INIT1, IDLE, EXEC, RESP, TRAP_SAVE, TRAP_VEC, MRET} state_t;

    localparam logic [2:0] IDX_MSTATUS = 3'd0;
    localparam logic [2:0] IDX_MTVEC   = 3'd1;
    localparam logic [2:0] IDX_MEPC    = 3'd2;
    localparam logic [2:0] IDX_MCAUSE  = 3'd3;
    localparam logic [2:0] IDX_MTVAL   = 3'd4;

    // Applies the architectural write mask of the target register.
    function automatic logic [31:0] wmask(input logic [2:0] idx, input logic [31:0] v);
        case (idx)
            IDX_MSTATUS:         wmask = (v & 32'h0000_0088) | 32'h0000_1800;
            IDX_MTVEC, IDX_MEPC: wmask = v & 32'hFFFF_FFFC;
            default:             wmask = v;
        endcase
    endfunction

    state_t      state_reg;
    logic [1:0]  op_reg;
    logic [2:0]  idx_reg;
    logic [31:0] src_reg;
    logic        illegal_reg;
    logic        src_zero_reg;
    logic [31:0] pc_reg, cause_reg, tval_reg;

    logic [2:0]  req_idx;
    logic        req_legal_addr;
    logic        unused_rd3;

    // Port 3 is write-only in every state.
    assign unused_rd3 = ^csr_rd3;

    always_comb begin
        req_legal_addr = 1'b1;
        req_idx        = IDX_MSTATUS;
        case (req_csr)
            12'h300: req_idx = IDX_MSTATUS;
            12'h305: req_idx = IDX_MTVEC;
            12'h341: req_idx = IDX_MEPC;
            12'h342: req_idx = IDX_MCAUSE;
            12'h343: req_idx = IDX_MTVAL;
            default: req_legal_addr = 1'b0;
        endcase
    end

    assign req_ready = (state_reg == IDLE) && !trap_valid && !mret_valid;
    assign trap_ack  = (state_reg == IDLE) && trap_valid;
    assign mret_ack  = (state_reg == IDLE) && !trap_valid && mret_valid;

    logic [31:0] exec_new;
    logic        exec_we;

    always_comb begin
        case (op_reg)
            2'b10:   exec_new = csr_rd1 | src_reg;
            2'b11:   exec_new = csr_rd1 & ~src_reg;
            default: exec_new = src_reg;
        endcase
        exec_we = !illegal_reg && !(op_reg[1] && src_zero_reg);
    end

    always_comb begin
        csr_addr1 = 12'd0; csr_we1 = 1'b0; csr_wd1 = 32'd0;
        csr_addr2 = 12'd0; csr_we2 = 1'b0; csr_wd2 = 32'd0;
        csr_addr3 = 12'd0; csr_we3 = 1'b0; csr_wd3 = 32'd0;
        case (state_reg)
            INIT0: begin
                csr_addr1 = {9'd0, IDX_MSTATUS}; csr_we1 = 1'b1; csr_wd1 = 32'h0000_1800;
                csr_addr2 = {9'd0, IDX_MTVEC};   csr_we2 = 1'b1; csr_wd2 = wmask(IDX_MTVEC, RESET_MTVEC);
                csr_addr3 = {9'd0, IDX_MEPC};    csr_we3 = 1'b1;
            end
            INIT1: begin
                csr_addr1 = {9'd0, IDX_MCAUSE};  csr_we1 = 1'b1;
                csr_addr2 = {9'd0, IDX_MTVAL};   csr_we2 = 1'b1;
            end
            EXEC: begin
                csr_addr1 = illegal_reg ? 12'd0 : {9'd0, idx_reg};
                csr_we1   = exec_we;
                csr_wd1   = exec_we ? wmask(idx_reg, exec_new) : 32'd0;
            end
            TRAP_SAVE: begin
                csr_addr1 = {9'd0, IDX_MEPC};    csr_we1 = 1'b1; csr_wd1 = wmask(IDX_MEPC, pc_reg);
                csr_addr2 = {9'd0, IDX_MCAUSE};  csr_we2 = 1'b1; csr_wd2 = cause_reg;
                csr_addr3 = {9'd0, IDX_MTVAL};   csr_we3 = 1'b1; csr_wd3 = tval_reg;
            end
            TRAP_VEC: begin
                // MPIE <- MIE, MIE <- 0; the mask restores MPP.
                csr_addr1 = {9'd0, IDX_MTVEC};
                csr_addr2 = {9'd0, IDX_MSTATUS}; csr_we2 = 1'b1;
                csr_wd2   = wmask(IDX_MSTATUS, {24'd0, csr_rd2[3], 7'd0});
            end
            MRET: begin
                csr_addr1 = {9'd0, IDX_MEPC};
                csr_addr2 = {9'd0, IDX_MSTATUS}; csr_we2 = 1'b1;
                csr_wd2   = wmask(IDX_MSTATUS, {24'd0, 1'b1, 3'd0, csr_rd2[7], 3'd0});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= INIT0;
            op_reg         <= 2'd0;
            idx_reg        <= 3'd0;
            src_reg        <= 32'd0;
            illegal_reg    <= 1'b0;
            src_zero_reg   <= 1'b0;
            pc_reg         <= 32'd0;
            cause_reg      <= 32'd0;
            tval_reg       <= 32'd0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_illegal   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            redirect_valid <= 1'b0;
            case (state_reg)
                INIT0: state_reg <= INIT1;
                INIT1: state_reg <= IDLE;
                IDLE: begin
                    if (trap_valid) begin
                        pc_reg    <= trap_pc;
                        cause_reg <= trap_cause;
                        tval_reg  <= trap_tval;
                        state_reg <= TRAP_SAVE;
                    end else if (mret_valid) begin
                        state_reg <= MRET;
                    end else if (req_valid) begin
                        op_reg       <= req_op[1:0];
                        idx_reg      <= req_idx;
                        src_reg      <= req_op[2] ? {27'd0, req_zimm} : req_rs1_val;
                        src_zero_reg <= req_src_zero;
                        illegal_reg  <= !req_legal_addr || (req_op[1:0] == 2'b00);
                        state_reg    <= EXEC;
                    end
                end
                EXEC: begin
                    resp_rdata   <= illegal_reg ? 32'd0 : csr_rd1;
                    resp_illegal <= illegal_reg;
                    resp_valid   <= 1'b1;
                    state_reg    <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                TRAP_SAVE: state_reg <= TRAP_VEC;
                TRAP_VEC: begin
                    redirect_pc    <= wmask(IDX_MTVEC, csr_rd1);
                    redirect_valid <= 1'b1;
                    state_reg      <= IDLE;
                end
                MRET: begin
                    redirect_pc    <= csr_rd1;
                    redirect_valid <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl with a behavioural 5-entry CSR file attached
// to the three ports; expected values are hand-computed constants.
module tb_csr_ctrl;
    localparam logic [31:0] RESET_MTVEC = 32'h0000_0103;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [11:0] req_csr = 12'd0;
    logic [31:0] req_rs1_val = 32'd0;
    logic [4:0]  req_zimm = 5'd0;
    logic        req_src_zero = 1'b0;
    logic        resp_valid, resp_ready = 1'b0, resp_illegal;
    logic [31:0] resp_rdata;
    logic        trap_valid = 1'b0, trap_ack;
    logic [31:0] trap_pc = 32'd0, trap_cause = 32'd0, trap_tval = 32'd0;
    logic        mret_valid = 1'b0, mret_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] csr_addr1, csr_addr2, csr_addr3;
    logic        csr_we1, csr_we2, csr_we3;
    logic [31:0] csr_wd1, csr_wd2, csr_wd3, csr_rd1, csr_rd2, csr_rd3;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [5];

    csr_ctrl #(.RESET_MTVEC(RESET_MTVEC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_csr(req_csr),
        .req_rs1_val(req_rs1_val), .req_zimm(req_zimm), .req_src_zero(req_src_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_illegal(resp_illegal),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .trap_ack(trap_ack),
        .mret_valid(mret_valid), .mret_ack(mret_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_addr1(csr_addr1), .csr_addr2(csr_addr2), .csr_addr3(csr_addr3),
        .csr_we1(csr_we1), .csr_we2(csr_we2), .csr_we3(csr_we3),
        .csr_wd1(csr_wd1), .csr_wd2(csr_wd2), .csr_wd3(csr_wd3),
        .csr_rd1(csr_rd1), .csr_rd2(csr_rd2), .csr_rd3(csr_rd3)
    );

    always #5 clk = ~clk;

    // CSR file model: combinational read, no reset.
    initial for (int i = 0; i < 5; i++) mem[i] = 32'h5A5A_5A5A;
    assign csr_rd1 = (csr_addr1 < 12'd5) ? mem[csr_addr1[2:0]] : 32'd0;
    assign csr_rd2 = (csr_addr2 < 12'd5) ? mem[csr_addr2[2:0]] : 32'd0;
    assign csr_rd3 = (csr_addr3 < 12'd5) ? mem[csr_addr3[2:0]] : 32'd0;
    always @(posedge clk) begin
        if (csr_we1 && csr_addr1 < 12'd5) mem[csr_addr1[2:0]] <= csr_wd1;
        if (csr_we2 && csr_addr2 < 12'd5) mem[csr_addr2[2:0]] <= csr_wd2;
        if (csr_we3 && csr_addr3 < 12'd5) mem[csr_addr3[2:0]] <= csr_wd3;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at a falling edge with the FSM in IDLE.
    task automatic do_csr(input string tag, input logic [2:0] op, input logic [11:0] csr,
                          input logic [31:0] rs1, input logic [4:0] zimm, input logic sz,
                          input logic [31:0] exp_rd, input logic exp_ill,
                          input logic exp_we, input logic [31:0] exp_wd);
        req_valid = 1'b1; req_op = op; req_csr = csr;
        req_rs1_val = rs1; req_zimm = zimm; req_src_zero = sz;
        #1 chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, " we"}, {31'd0, csr_we1}, {31'd0, exp_we});
        chk({tag, " wd"}, csr_wd1, exp_wd);
        @(negedge clk);
        chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, " rdata"}, resp_rdata, exp_rd);
        chk({tag, " illegal"}, {31'd0, resp_illegal}, {31'd0, exp_ill});
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " resp_done"}, {31'd0, resp_valid}, 32'd0);
        $display("op %s: csr=%h rdata=%h illegal=%0d", tag, csr, resp_rdata, resp_illegal);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst redirect_pc", redirect_pc, 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst illegal", {31'd0, resp_illegal}, 32'd0);
        rst = 1'b0;
        #1;
        chk("init0 wd1", csr_wd1, 32'h0000_1800);
        chk("init0 addr2", {20'd0, csr_addr2}, 32'd1);
        chk("init0 wd2", csr_wd2, 32'h0000_0100);
        chk("init0 we3", {31'd0, csr_we3}, 32'd1);
        chk("init0 ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("init1 addr1", {20'd0, csr_addr1}, 32'd3);
        chk("init1 addr2", {20'd0, csr_addr2}, 32'd4);
        chk("init1 we3", {31'd0, csr_we3}, 32'd0);
        chk("init1 ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);

        //      tag      op     csr      rs1            zimm  sz    rdata          ill   we    wd
        do_csr("rs0",    3'b010, 12'h300, 32'h0,         5'd0, 1'b1, 32'h0000_1800, 1'b0, 1'b0, 32'h0);
        do_csr("rw_tv",  3'b001, 12'h305, 32'h8000_0103, 5'd0, 1'b0, 32'h0000_0100, 1'b0, 1'b1, 32'h8000_0100);
        do_csr("rs_tv",  3'b010, 12'h305, 32'h0,         5'd0, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'h0);
        do_csr("rsi_ms", 3'b110, 12'h300, 32'h0,         5'd8, 1'b0, 32'h0000_1800, 1'b0, 1'b1, 32'h0000_1808);
        do_csr("rc_ms",  3'b011, 12'h300, 32'h8,         5'd0, 1'b0, 32'h0000_1808, 1'b0, 1'b1, 32'h0000_1800);
        do_csr("rw_ms",  3'b001, 12'h300, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0000_1800, 1'b0, 1'b1, 32'h0000_1888);
        do_csr("rc_mp",  3'b011, 12'h300, 32'h80,        5'd0, 1'b0, 32'h0000_1888, 1'b0, 1'b1, 32'h0000_1808);
        do_csr("rw_tv2", 3'b001, 12'h305, 32'h203,       5'd0, 1'b0, 32'h8000_0100, 1'b0, 1'b1, 32'h0000_0200);
        do_csr("rw_epc", 3'b001, 12'h341, 32'h7,         5'd0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4);
        do_csr("rwi_mc", 3'b101, 12'h342, 32'h0,         5'h1F,1'b0, 32'h0,         1'b0, 1'b1, 32'h1F);
        do_csr("rci0",   3'b111, 12'h342, 32'h0,         5'd0, 1'b1, 32'h1F,        1'b0, 1'b0, 32'h0);
        do_csr("ill344", 3'b001, 12'h344, 32'h1234,      5'd0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0);
        do_csr("ill_op0",3'b000, 12'h300, 32'hFF,        5'd0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0);
        do_csr("ill_op4",3'b100, 12'h305, 32'hFF,        5'd0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0);

        // Trap entry with MIE=1, mtvec=0x200.
        trap_valid = 1'b1; trap_pc = 32'h0000_0104; trap_cause = 32'd2; trap_tval = 32'hDEAD_BEEF;
        #1 chk("trap ack", {31'd0, trap_ack}, 32'd1);
        @(negedge clk);
        trap_valid = 1'b0;
        chk("tsave ack", {31'd0, trap_ack}, 32'd0);
        chk("tsave wd1", csr_wd1, 32'h0000_0104);
        chk("tsave wd3", csr_wd3, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("tvec wd2", csr_wd2, 32'h0000_1880);
        chk("tvec redir", {31'd0, redirect_valid}, 32'd0);
        @(negedge clk);
        chk("trap redir", {31'd0, redirect_valid}, 32'd1);
        chk("trap pc", redirect_pc, 32'h0000_0200);
        chk("trap mepc", mem[2], 32'h0000_0104);
        chk("trap mcause", mem[3], 32'd2);
        chk("trap mtval", mem[4], 32'hDEAD_BEEF);
        chk("trap mstatus", mem[0], 32'h0000_1880);
        $display("trap: redirect_pc=%h mstatus=%h", redirect_pc, mem[0]);

        mret_valid = 1'b1;
        #1 chk("mret ack", {31'd0, mret_ack}, 32'd1);
        @(negedge clk);
        mret_valid = 1'b0;
        chk("mret redir early", {31'd0, redirect_valid}, 32'd0);
        @(negedge clk);
        chk("mret redir", {31'd0, redirect_valid}, 32'd1);
        chk("mret pc", redirect_pc, 32'h0000_0104);
        chk("mret mstatus", mem[0], 32'h0000_1888);
        $display("mret: redirect_pc=%h mstatus=%h", redirect_pc, mem[0]);
        @(negedge clk);
        chk("redir pulse", {31'd0, redirect_valid}, 32'd0);

        // Trap + mret raised while an op is in flight and resp_ready is held low.
        req_valid = 1'b1; req_op = 3'b010; req_csr = 12'h343; req_src_zero = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        trap_valid = 1'b1; mret_valid = 1'b1;
        trap_pc = 32'h0000_0302; trap_cause = 32'h8000_000B; trap_tval = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold trap_ack", {31'd0, trap_ack}, 32'd0);
        end
        chk("hold rdata", resp_rdata, 32'hDEAD_BEEF);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("both trap_ack", {31'd0, trap_ack}, 32'd1);
        chk("both mret_ack", {31'd0, mret_ack}, 32'd0);
        @(negedge clk);
        trap_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("both trap redir", {31'd0, redirect_valid}, 32'd1);
        chk("both trap pc", redirect_pc, 32'h0000_0200);
        chk("both mret_ack2", {31'd0, mret_ack}, 32'd1);
        @(negedge clk);
        mret_valid = 1'b0;
        @(negedge clk);
        chk("both mret redir", {31'd0, redirect_valid}, 32'd1);
        chk("both mret pc", redirect_pc, 32'h0000_0300);
        chk("both mcause", mem[3], 32'h8000_000B);
        chk("both mstatus", mem[0], 32'h0000_1888);
        $display("trap+mret: final redirect_pc=%h", redirect_pc);

        // Reset mid-op aborts and reruns init.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b001; req_csr = 12'h342; req_rs1_val = 32'h55; req_src_zero = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reinit ready2", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("reinit ready3", {31'd0, req_ready}, 32'd1);
        do_csr("re_mc",  3'b010, 12'h342, 32'h0,         5'd0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
